// File: rtl/axis_frame_stream_engine.sv
// AXI-Stream frame adapter around a fixed-latency, non-stallable pixel core.
// Tracks line/frame position, tags beats with SOF/EOL, and retimes results via a credit-guarded FIFO.
module axis_frame_stream_engine #(
   parameter int DATA_W     = 32,
   parameter int FRAME_W    = 720,
   parameter int FRAME_H    = 480,
   parameter int CNT_W      = 10,
   parameter int CORE_LAT   = 4,
   parameter int FIFO_DEPTH = 16
) (
   input  logic                axi_Mclk,
   input  logic                reset,
   input  logic                enable,
   input  logic [DATA_W-1:0]   s_axis_tdata,
   input  logic                s_axis_tvalid,
   output logic                s_axis_tready,
   input  logic                s_axis_tlast,
   output logic [DATA_W-1:0]   m_axis_tdata,
   output logic                m_axis_tvalid,
   input  logic                m_axis_tready,
   output logic [DATA_W/8-1:0] m_axis_tkeep,
   output logic                m_axis_tlast,
   output logic                m_axis_tuser,
   output logic                core_pix_en,
   output logic [DATA_W-1:0]   core_din,
   input  logic [DATA_W-1:0]   core_dout,
   output logic [CNT_W-1:0]    hs_cnt,
   output logic [CNT_W-1:0]    vs_cnt,
   output logic                busy,
   output logic                frame_intr,
   output logic                err_tlast
);
   localparam int KEEP_W = DATA_W / 8;
   localparam int PTR_W  = $clog2(FIFO_DEPTH);
   localparam int CW     = PTR_W + 1;
   localparam int SW     = CW + 1;

   typedef enum logic [1:0] {IDLE, RUN, DRAIN, DONE} state_t;

   state_t                     state_reg, state_next;
   logic                       s_ready_reg, s_ready_next;
   logic [CNT_W-1:0]           hs_cnt_reg, vs_cnt_reg;
   logic                       err_reg;
   logic                       accept, sof, eol, last_pix;
   logic [CORE_LAT-1:0]        pipe_vld_reg, pipe_vld_next;
   logic [CORE_LAT-1:0][1:0]   pipe_tag_reg, pipe_tag_next;
   logic [CW-1:0]              inflight_reg, inflight_next;
   logic [CW-1:0]              fifo_cnt_reg, fifo_cnt_next;
   logic [PTR_W-1:0]           wr_ptr_reg, rd_ptr_reg;
   logic [DATA_W+1:0]          fifo_mem [FIFO_DEPTH];
   logic [DATA_W+1:0]          head;
   logic                       push, pop, m_valid, fifo_full;
   logic [SW-1:0]              credit_sum;

   assign accept   = s_axis_tvalid & s_ready_reg;
   assign eol      = (hs_cnt_reg == CNT_W'(FRAME_W - 1));
   assign sof      = (hs_cnt_reg == '0) && (vs_cnt_reg == '0);
   assign last_pix = eol && (vs_cnt_reg == CNT_W'(FRAME_H - 1));

   // Tag/valid delay line runs in lockstep with the core so each result meets its tag.
   genvar gi;
   generate
      for (gi = 0; gi < CORE_LAT; gi++) begin : g_pipe
         if (gi == 0) begin : g_head
            assign pipe_vld_next[gi] = accept;
            assign pipe_tag_next[gi] = {sof, eol};
         end else begin : g_tail
            assign pipe_vld_next[gi] = pipe_vld_reg[gi-1];
            assign pipe_tag_next[gi] = pipe_tag_reg[gi-1];
         end
      end
   endgenerate

   assign push          = pipe_vld_reg[CORE_LAT-1];
   assign m_valid       = (fifo_cnt_reg != '0);
   assign pop           = m_valid & m_axis_tready;
   assign fifo_full     = (fifo_cnt_reg == CW'(FIFO_DEPTH));
   assign inflight_next = inflight_reg + CW'(accept) - CW'(push);
   assign fifo_cnt_next = fifo_cnt_reg + CW'(push) - CW'(pop);
   // One slot is reserved for the beat that a ready asserted now could admit next cycle.
   assign credit_sum    = SW'(fifo_cnt_next) + SW'(inflight_next) + SW'(1);

   always_comb begin
      state_next   = state_reg;
      s_ready_next = 1'b0;
      case (state_reg)
         IDLE:    if (enable) state_next = RUN;
         RUN:     if (accept && last_pix) state_next = DRAIN;
         DRAIN:   if ((fifo_cnt_reg == '0) && (inflight_reg == '0)) state_next = DONE;
         DONE:    state_next = enable ? RUN : IDLE;
         default: state_next = IDLE;
      endcase
      if ((state_next == RUN) && (credit_sum < SW'(FIFO_DEPTH)))
         s_ready_next = 1'b1;
   end

   always_ff @(posedge axi_Mclk) begin
      if (reset) begin
         state_reg    <= IDLE;
         s_ready_reg  <= 1'b0;
         pipe_vld_reg <= '0;
         pipe_tag_reg <= '0;
         inflight_reg <= '0;
         fifo_cnt_reg <= '0;
         wr_ptr_reg   <= '0;
         rd_ptr_reg   <= '0;
      end else begin
         state_reg    <= state_next;
         s_ready_reg  <= s_ready_next;
         pipe_vld_reg <= pipe_vld_next;
         pipe_tag_reg <= pipe_tag_next;
         inflight_reg <= inflight_next;
         fifo_cnt_reg <= fifo_cnt_next;
         if (push) wr_ptr_reg <= wr_ptr_reg + PTR_W'(1);
         if (pop)  rd_ptr_reg <= rd_ptr_reg + PTR_W'(1);
      end
   end

   always_ff @(posedge axi_Mclk) begin
      if (push) fifo_mem[wr_ptr_reg] <= {pipe_tag_reg[CORE_LAT-1], core_dout};
   end

   always_ff @(posedge axi_Mclk) begin
      if (reset) begin
         hs_cnt_reg <= '0;
         vs_cnt_reg <= '0;
         err_reg    <= 1'b0;
      end else if ((state_reg == IDLE) && enable) begin
         hs_cnt_reg <= '0;
         vs_cnt_reg <= '0;
         err_reg    <= 1'b0;
      end else if (accept) begin
         if (eol) begin
            hs_cnt_reg <= '0;
            vs_cnt_reg <= last_pix ? '0 : vs_cnt_reg + CNT_W'(1);
         end else begin
            hs_cnt_reg <= hs_cnt_reg + CNT_W'(1);
         end
         if (s_axis_tlast != eol) err_reg <= 1'b1;
      end
   end

   assign head          = fifo_mem[rd_ptr_reg];
   assign s_axis_tready = s_ready_reg;
   assign m_axis_tvalid = m_valid;
   assign m_axis_tdata  = m_valid ? head[DATA_W-1:0] : '0;
   assign m_axis_tlast  = m_valid & head[DATA_W];
   assign m_axis_tuser  = m_valid & head[DATA_W+1];
   assign m_axis_tkeep  = {KEEP_W{m_valid}};
   assign core_pix_en   = accept;
   assign core_din      = accept ? s_axis_tdata : '0;
   assign hs_cnt        = hs_cnt_reg;
   assign vs_cnt        = vs_cnt_reg;
   assign busy          = (state_reg != IDLE);
   assign frame_intr    = (state_reg == DONE);
   assign err_tlast     = err_reg;

   // The credit scheme must never let a core result arrive at a full FIFO.
   assert property (@(posedge axi_Mclk) disable iff (reset) !(push && fifo_full));

endmodule

// File: tb/tb_axis_frame_stream_engine.sv
// Scoreboard bench for axis_frame_stream_engine with an identity core model.
// Expected beats are queued on input acceptance and checked as the DUT emits them.
module tb_axis_frame_stream_engine;
   localparam int DATA_W     = 32;
   localparam int FRAME_W    = 4;
   localparam int FRAME_H    = 2;
   localparam int CNT_W      = 10;
   localparam int CORE_LAT   = 3;
   localparam int FIFO_DEPTH = 8;
   localparam int NPIX       = FRAME_W * FRAME_H;

   logic                axi_Mclk, reset, enable;
   logic [DATA_W-1:0]   s_axis_tdata;
   logic                s_axis_tvalid, s_axis_tready, s_axis_tlast;
   logic [DATA_W-1:0]   m_axis_tdata;
   logic                m_axis_tvalid, m_axis_tready, m_axis_tlast, m_axis_tuser;
   logic [DATA_W/8-1:0] m_axis_tkeep;
   logic                core_pix_en;
   logic [DATA_W-1:0]   core_din, core_dout;
   logic [CNT_W-1:0]    hs_cnt, vs_cnt;
   logic                busy, frame_intr, err_tlast;

   axis_frame_stream_engine #(
      .DATA_W(DATA_W), .FRAME_W(FRAME_W), .FRAME_H(FRAME_H), .CNT_W(CNT_W),
      .CORE_LAT(CORE_LAT), .FIFO_DEPTH(FIFO_DEPTH)
   ) dut (
      .axi_Mclk(axi_Mclk), .reset(reset), .enable(enable),
      .s_axis_tdata(s_axis_tdata), .s_axis_tvalid(s_axis_tvalid),
      .s_axis_tready(s_axis_tready), .s_axis_tlast(s_axis_tlast),
      .m_axis_tdata(m_axis_tdata), .m_axis_tvalid(m_axis_tvalid),
      .m_axis_tready(m_axis_tready), .m_axis_tkeep(m_axis_tkeep),
      .m_axis_tlast(m_axis_tlast), .m_axis_tuser(m_axis_tuser),
      .core_pix_en(core_pix_en), .core_din(core_din), .core_dout(core_dout),
      .hs_cnt(hs_cnt), .vs_cnt(vs_cnt), .busy(busy),
      .frame_intr(frame_intr), .err_tlast(err_tlast)
   );

   initial axi_Mclk = 1'b0;
   always #5 axi_Mclk = ~axi_Mclk;

   // Identity core: result appears CORE_LAT cycles after the strobe.
   logic [DATA_W-1:0] core_dly [CORE_LAT];
   always @(posedge axi_Mclk) begin
      core_dly[0] <= core_din;
      for (int k = 1; k < CORE_LAT; k++) core_dly[k] <= core_dly[k-1];
   end
   assign core_dout = core_dly[CORE_LAT-1];

   typedef struct packed {
      logic [DATA_W-1:0] data;
      logic              user;
      logic              last;
   } beat_t;

   beat_t sb[$];
   int    tests_run = 0, tests_failed = 0;
   int    cycle = 0, pix_idx = 0, acc_total = 0, beat_total = 0, intr_count = 0, sof_cycle = 0;
   logic  prev_valid = 1'b0, prev_intr = 1'b0, held_stall = 1'b0, err_pending = 1'b0, exp_err = 1'b0;
   logic [38:0] held_vec = '0;

   task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
      tests_run++;
      if (got !== exp) begin
         tests_failed++;
         $display("FAIL %s: got %0h expected %0h", tag, got, exp);
      end
   endtask

   always @(negedge axi_Mclk) begin
      beat_t e;
      logic [38:0] cur_vec;
      cycle++;
      cur_vec = {m_axis_tvalid, m_axis_tlast, m_axis_tuser, m_axis_tkeep, m_axis_tdata};
      if (reset) begin
         sb.delete();
         pix_idx     = 0;
         prev_valid  = 1'b0;
         prev_intr   = 1'b0;
         held_stall  = 1'b0;
         err_pending = 1'b0;
      end else begin
         if (err_pending) begin
            chk("err_next_cycle", 64'(err_tlast), 64'd1);
            err_pending = 1'b0;
         end
         if (m_axis_tvalid && !prev_valid && m_axis_tuser)
            chk("sof_latency", 64'(cycle - sof_cycle), 64'(CORE_LAT + 1));
         if (held_stall) chk("stall_stable", 64'(cur_vec), 64'(held_vec));
         if (m_axis_tvalid && m_axis_tready) begin
            beat_total++;
            if (sb.size() == 0) begin
               chk("unexpected_beat", 64'd1, 64'd0);
            end else begin
               e = sb.pop_front();
               $display("[TB] beat %0d data=%0d tuser=%0b tlast=%0b", beat_total, m_axis_tdata,
                        m_axis_tuser, m_axis_tlast);
               chk("beat_data", 64'(m_axis_tdata), 64'(e.data));
               chk("beat_tuser", 64'(m_axis_tuser), 64'(e.user));
               chk("beat_tlast", 64'(m_axis_tlast), 64'(e.last));
               chk("beat_tkeep", 64'(m_axis_tkeep), 64'hf);
            end
         end
         if (s_axis_tvalid && s_axis_tready) begin
            acc_total++;
            chk("core_strobe", 64'({core_pix_en, core_din}), 64'({1'b1, s_axis_tdata}));
            e.data = s_axis_tdata;
            e.user = (pix_idx == 0);
            e.last = ((pix_idx % FRAME_W) == FRAME_W - 1);
            if (pix_idx == 0) sof_cycle = cycle;
            if (s_axis_tlast != e.last) err_pending = 1'b1;
            sb.push_back(e);
            pix_idx = (pix_idx + 1) % NPIX;
         end
         if (prev_intr) chk("intr_pulse_width", 64'(frame_intr), 64'd0);
         if (frame_intr) begin
            intr_count++;
            chk("intr_after_last_beat", 64'(sb.size()), 64'd0);
            chk("intr_hs_vs_zero", 64'({hs_cnt, vs_cnt}), 64'd0);
            chk("err_at_done", 64'(err_tlast), 64'(exp_err));
         end
         held_stall = m_axis_tvalid && !m_axis_tready;
         held_vec   = cur_vec;
         prev_valid = m_axis_tvalid;
         prev_intr  = frame_intr;
      end
   end

   task automatic start_frame();
      enable = 1'b1;
      @(posedge axi_Mclk); #1;
      enable = 1'b0;
   endtask

   task automatic send_beats(input int n, input int base, input int bad_idx);
      int w;
      for (int i = 0; i < n; i++) begin
         s_axis_tdata  = DATA_W'(base + i);
         s_axis_tvalid = 1'b1;
         s_axis_tlast  = ((i % FRAME_W) == FRAME_W - 1) ^ (i == bad_idx);
         w = 0;
         @(negedge axi_Mclk);
         while (!s_axis_tready && w < 2000) begin
            @(negedge axi_Mclk);
            w++;
         end
         if (!s_axis_tready) begin
            chk("accept_timeout", 64'd0, 64'd1);
            break;
         end
         @(posedge axi_Mclk); #1;
      end
      s_axis_tvalid = 1'b0;
      s_axis_tlast  = 1'b0;
   endtask

   task automatic wait_intr(input int target);
      int w = 0;
      while (intr_count < target && w < 500) begin
         @(posedge axi_Mclk);
         w++;
      end
      #1;
      chk("intr_wait", 64'(intr_count), 64'(target));
   endtask

   task automatic chk_all_zero(input string tag);
      chk({tag, "_ctrl"}, 64'({s_axis_tready, m_axis_tvalid, m_axis_tkeep, m_axis_tlast, m_axis_tuser,
                              core_pix_en, busy, frame_intr, err_tlast, hs_cnt, vs_cnt}), 64'd0);
      chk({tag, "_mdata"}, 64'(m_axis_tdata), 64'd0);
      chk({tag, "_cdin"}, 64'(core_din), 64'd0);
   endtask

   initial begin
      int a0, b0;
      reset = 1'b1; enable = 1'b0; m_axis_tready = 1'b1;
      s_axis_tdata = '0; s_axis_tvalid = 1'b0; s_axis_tlast = 1'b0;
      repeat (3) @(posedge axi_Mclk);
      #1;
      chk_all_zero("reset");
      reset = 1'b0;

      // Single frame, free-flowing output.
      b0 = beat_total;
      start_frame();
      send_beats(NPIX, 1, -1);
      wait_intr(1);
      chk("frame1_beats", 64'(beat_total - b0), 64'(NPIX));

      // Downstream stalled: credit limit must hold the input off.
      m_axis_tready = 1'b0;
      a0 = acc_total;
      b0 = beat_total;
      start_frame();
      fork
         send_beats(NPIX, 21, -1);
         begin
            repeat (40) @(posedge axi_Mclk);
            #2;
            chk("credit_accepts", 64'(acc_total - a0), 64'(FIFO_DEPTH - 1));
            chk("credit_tready_low", 64'(s_axis_tready), 64'd0);
            chk("credit_tvalid", 64'(m_axis_tvalid), 64'd1);
            m_axis_tready = 1'b1;
         end
      join
      wait_intr(2);
      chk("stall_beats", 64'(beat_total - b0), 64'(NPIX));

      // Bad TLAST on beat 2; flag persists into IDLE, clears at next start.
      exp_err = 1'b1;
      start_frame();
      send_beats(NPIX, 41, 1);
      wait_intr(3);
      chk("err_idle_hold", 64'(err_tlast), 64'd1);
      exp_err = 1'b0;
      start_frame();
      chk("err_cleared", 64'(err_tlast), 64'd0);
      send_beats(NPIX, 51, -1);
      wait_intr(4);

      // Reset mid-frame after 5 accepts.
      start_frame();
      send_beats(5, 61, -1);
      reset = 1'b1;
      @(posedge axi_Mclk); #1;
      chk_all_zero("midrst");
      reset = 1'b0;
      b0 = beat_total;
      start_frame();
      send_beats(NPIX, 71, -1);
      wait_intr(5);
      chk("post_rst_beats", 64'(beat_total - b0), 64'(NPIX));

      // Back-to-back frames with enable held.
      b0 = beat_total;
      enable = 1'b1;
      @(posedge axi_Mclk); #1;
      send_beats(2 * NPIX, 81, -1);
      enable = 1'b0;
      wait_intr(7);
      chk("cont_beats", 64'(beat_total - b0), 64'(2 * NPIX));
      repeat (3) @(posedge axi_Mclk);
      #1;
      chk("final_idle", 64'({busy, hs_cnt, vs_cnt}), 64'd0);
      chk("sb_empty", 64'(sb.size()), 64'd0);

      $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

endmodule
